// File: rtl/nes_poll_sequencer.sv
// nes_poll_sequencer: drives the NES controller 4021 shift register (latch + shift clock),
// deserialises the eight button bits and publishes them as a registered parallel byte.
// Frames start from an internal poll timer or from an on-demand request.
`timescale 1ns/1ps

module nes_poll_sequencer #(
  parameter int unsigned HALF        = 300,
  parameter int unsigned POLL_PERIOD = 833333
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       poll_now,
  input  logic       sdata,
  output logic       srlatch,
  output logic       srclk,
  output logic [7:0] buttons,
  output logic       valid,
  output logic       changed,
  output logic       busy
);

  // Counter widths and terminal counts
  localparam int unsigned TMR_W = $clog2(POLL_PERIOD);
  localparam int unsigned PH_W  = $clog2(2 * HALF);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(POLL_PERIOD - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * HALF - 1);
  localparam logic [PH_W-1:0]  LOW_LAST = PH_W'(HALF - 1);
  localparam logic [PH_W-1:0]  HALF_PH  = PH_W'(HALF);

  // Frame states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LATCH = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]       r_sync;
  logic [1:0]       r_state;
  logic [TMR_W-1:0] r_tmr;
  logic [PH_W-1:0]  r_ph;
  logic [2:0]       r_bit;
  logic [7:0]       r_shreg;
  logic             r_srlatch;
  logic             r_srclk;
  logic [7:0]       r_buttons;
  logic             r_valid;
  logic             r_changed;
  logic             r_busy;

  logic             w_sd_s;
  logic             w_expire;
  logic             w_start;
  logic             w_ph_end;
  logic             w_capture;
  logic             w_enter_done;
  logic [1:0]       w_state_nx;
  logic [PH_W-1:0]  w_ph_nx;
  logic [2:0]       w_bit_nx;

  assign w_sd_s       = r_sync[1];
  assign w_expire     = en && (r_tmr == TMR_LAST);
  assign w_start      = (r_state == ST_IDLE) && (w_expire || poll_now);
  assign w_ph_end     = (r_ph == PH_LAST);
  assign w_capture    = (r_state == ST_SHIFT) && (r_ph == LOW_LAST);
  assign w_enter_done = (r_state == ST_SHIFT) && (w_state_nx == ST_DONE);

  // Two-flop synchroniser for the asynchronous controller data line
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], sdata};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state logic: latch pulse, eight shift bits, one publish cycle
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nx = ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (w_ph_end) begin
          w_state_nx = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_ph_end && (r_bit == 3'd7)) begin
          w_state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // Next phase and bit index; both restart at every state boundary
  always_comb begin
    w_ph_nx  = '0;
    w_bit_nx = '0;
    if ((r_state == ST_LATCH) || (r_state == ST_SHIFT)) begin
      if (!w_ph_end) begin
        w_ph_nx = r_ph + PH_W'(1);
      end
    end
    if (r_state == ST_SHIFT) begin
      if (w_ph_end) begin
        w_bit_nx = r_bit + 3'd1;
      end else begin
        w_bit_nx = r_bit;
      end
    end
  end

  // Phase counter and bit index registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ph  <= '0;
      r_bit <= '0;
    end else begin
      r_ph  <= w_ph_nx;
      r_bit <= w_bit_nx;
    end
  end

  // Poll timer: free-runs while enabled, held at zero otherwise, restarted by every frame
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmr <= '0;
    end else if (!en || w_start) begin
      r_tmr <= '0;
    end else if (r_tmr == TMR_LAST) begin
      r_tmr <= '0;
    end else begin
      r_tmr <= r_tmr + TMR_W'(1);
    end
  end

  // Capture one button per shift bit on the last low cycle; data is active-low
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg <= '0;
    end else if (w_capture) begin
      r_shreg[r_bit] <= ~w_sd_s;
    end
  end

  // Pin strobes and busy flag, registered from the upcoming state and phase
  always_ff @(posedge clk) begin
    if (reset) begin
      r_srlatch <= 1'b0;
      r_srclk   <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_srlatch <= (w_state_nx == ST_LATCH);
      r_srclk   <= !((w_state_nx == ST_SHIFT) && (w_ph_nx < HALF_PH));
      r_busy    <= (w_state_nx != ST_IDLE);
    end
  end

  // Publish the frame: buttons, valid strobe and change flag appear during DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buttons <= '0;
      r_valid   <= 1'b0;
      r_changed <= 1'b0;
    end else begin
      r_valid   <= w_enter_done;
      r_changed <= w_enter_done && (r_shreg != r_buttons);
      if (w_enter_done) begin
        r_buttons <= r_shreg;
      end
    end
  end

  assign srlatch = r_srlatch;
  assign srclk   = r_srclk;
  assign buttons = r_buttons;
  assign valid   = r_valid;
  assign changed = r_changed;
  assign busy    = r_busy;

endmodule

// File: tb/tb_nes_poll_sequencer.sv
// Bench for nes_poll_sequencer: 4021 controller model plus frame-level reference checks.
`timescale 1ns/1ps

module tb_nes_poll_sequencer;

  localparam int unsigned HALF        = 4;
  localparam int unsigned POLL_PERIOD = 100;
  localparam int          OBS_LEN     = 80;
  localparam int          LATCH_LEN   = 2 * HALF;
  localparam int          VALID_OFF   = 18 * HALF;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       en       = 1'b0;
  logic       poll_now = 1'b0;
  logic       sdata    = 1'b1;
  logic       srlatch;
  logic       srclk;
  logic [7:0] buttons;
  logic       valid;
  logic       changed;
  logic       busy;

  int         n_checks = 0;
  int         n_errors = 0;

  logic [7:0] pad      = 8'h00;
  logic [7:0] exp_prev = 8'h00;
  int         pad_idx  = 8;
  logic       pad_prev_clk = 1'b1;

  always #5 clk = ~clk;

  nes_poll_sequencer #(
    .HALF        (HALF),
    .POLL_PERIOD (POLL_PERIOD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .poll_now (poll_now),
    .sdata    (sdata),
    .srlatch  (srlatch),
    .srclk    (srclk),
    .buttons  (buttons),
    .valid    (valid),
    .changed  (changed),
    .busy     (busy)
  );

  // 4021 controller: parallel load while latched, shift on srclk rising edge, A first, active-low
  always @(negedge clk) begin
    if (srlatch === 1'b1) begin
      pad_idx = 0;
    end else if (srclk === 1'b1 && pad_prev_clk === 1'b0 && pad_idx < 8) begin
      pad_idx = pad_idx + 1;
    end
    pad_prev_clk = srclk;
    sdata = (pad_idx < 8) ? ~pad[pad_idx[2:0]] : 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until srlatch is seen high, at most max cycles
  task automatic wait_rise(input int max, output int n);
    n = 0;
    while (srlatch !== 1'b1 && n < max) begin
      tick();
      n++;
    end
  endtask

  // From the current cycle L+80, request a poll at cycle L+d; srlatch must rise one cycle later
  task automatic poll_after(input int d);
    repeat (d - OBS_LEN) tick();
    check("pre_poll_latch_low", 32'(srlatch), 32'd0);
    poll_now = 1'b1;
    tick();
    poll_now = 1'b0;
    check("poll_latch_rise", 32'(srlatch), 32'd1);
  endtask

  // Count cycles of srlatch/valid activity over a quiet window
  task automatic quiet(input int cycles, input string tag);
    int act;
    act = 0;
    for (int k = 0; k < cycles; k++) begin
      if (srlatch !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) act++;
      tick();
    end
    check(tag, 32'(act), 32'd0);
  endtask

  // Observe one frame starting at the first srlatch-high cycle and compare against the frame rules
  task automatic observe_frame(input int poll_off, input int endrop_off, input logic [7:0] exp_btn);
    int   latch_win, latch_tot, lows, falls, rises, first_fall, nvalid, valid_off, nbusy;
    logic prev_clk;
    logic [7:0] b_at_v;
    logic c_at_v;
    logic exp_chg;
    latch_win = 0; latch_tot = 0; lows = 0; falls = 0; rises = 0;
    first_fall = -1; nvalid = 0; valid_off = -1; nbusy = 0;
    prev_clk = 1'b1; b_at_v = 8'h00; c_at_v = 1'b0;
    exp_chg = (exp_btn != exp_prev);
    for (int k = 0; k < OBS_LEN; k++) begin
      if (srlatch === 1'b1) begin
        latch_tot++;
        if (k < LATCH_LEN) latch_win++;
      end
      if (srclk === 1'b0) lows++;
      if (prev_clk === 1'b1 && srclk === 1'b0) begin
        falls++;
        if (first_fall < 0) first_fall = k;
      end
      if (prev_clk === 1'b0 && srclk === 1'b1) rises++;
      prev_clk = srclk;
      if (busy === 1'b1) nbusy++;
      if (valid === 1'b1) begin
        nvalid++;
        if (valid_off < 0) begin
          valid_off = k;
          b_at_v    = buttons;
          c_at_v    = changed;
        end
      end
      poll_now = (k == poll_off);
      if (k == endrop_off) en = 1'b0;
      tick();
    end
    poll_now = 1'b0;
    check("latch_window",  32'(latch_win),  32'(LATCH_LEN));
    check("latch_total",   32'(latch_tot),  32'(LATCH_LEN));
    check("srclk_falls",   32'(falls),      32'd8);
    check("srclk_rises",   32'(rises),      32'd8);
    check("srclk_lowcyc",  32'(lows),       32'(8 * HALF));
    check("first_fall",    32'(first_fall), 32'(LATCH_LEN));
    check("valid_count",   32'(nvalid),     32'd1);
    check("valid_offset",  32'(valid_off),  32'(VALID_OFF));
    check("busy_cycles",   32'(nbusy),      32'(VALID_OFF + 1));
    check("buttons",       32'(b_at_v),     32'(exp_btn));
    check("changed",       32'(c_at_v),     32'(exp_chg));
    check("buttons_hold",  32'(buttons),    32'(exp_btn));
    exp_prev = exp_btn;
  endtask

  initial begin
    int n;
    int d;

    // Reset with timer enabled and an idle controller
    reset = 1'b1;
    en    = 1'b1;
    pad   = 8'h00;
    repeat (3) tick();
    check("rst_srlatch", 32'(srlatch), 32'd0);
    check("rst_srclk",   32'(srclk),   32'd1);
    check("rst_buttons", 32'(buttons), 32'd0);
    check("rst_valid",   32'(valid),   32'd0);
    check("rst_changed", 32'(changed), 32'd0);
    check("rst_busy",    32'(busy),    32'd0);

    // Timer poll: first srlatch high in cycle POLL_PERIOD after release
    reset = 1'b0;
    repeat (POLL_PERIOD - 1) tick();
    check("timer_pre_rise", 32'(srlatch), 32'd0);
    tick();
    check("timer_first_rise", 32'(srlatch), 32'd1);
    observe_frame(-1, -1, 8'h00);

    // Deserialise A and R pressed, then an identical frame
    pad = 8'h81;
    wait_rise(200, n);
    check("timer_period", 32'(n), 32'(POLL_PERIOD - OBS_LEN));
    observe_frame(-1, -1, 8'h81);
    wait_rise(200, n);
    check("timer_period", 32'(n), 32'(POLL_PERIOD - OBS_LEN));
    observe_frame(-1, -1, 8'h81);

    // Random button patterns with timer or poll_now triggers
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 3) != 0) pad = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        d = int'($urandom_range(OBS_LEN, POLL_PERIOD - 1));
        poll_after(d);
      end else begin
        wait_rise(200, n);
        check("timer_period", 32'(n), 32'(POLL_PERIOD - OBS_LEN));
      end
      observe_frame(-1, -1, pad);
    end

    // en drops during LATCH: frame still completes, then the timer stays silent
    pad = 8'($urandom);
    wait_rise(200, n);
    check("timer_period", 32'(n), 32'(POLL_PERIOD - OBS_LEN));
    observe_frame(-1, 3, pad);
    quiet(300, "en_drop_quiet");

    // poll_now with en low; a second request during SHIFT is ignored
    pad = 8'($urandom);
    poll_now = 1'b1;
    tick();
    poll_now = 1'b0;
    check("poll_en0_rise", 32'(srlatch), 32'd1);
    observe_frame(LATCH_LEN + 3 * 2 * HALF + 1, -1, pad);
    quiet(150, "poll_en0_quiet");

    // poll_now coincident with timer expiry: one frame, timer restarted
    pad = 8'($urandom_range(1, 255));
    en  = 1'b1;
    repeat (POLL_PERIOD - 1) tick();
    check("sim_pre_rise", 32'(srlatch), 32'd0);
    poll_now = 1'b1;
    tick();
    poll_now = 1'b0;
    check("sim_rise", 32'(srlatch), 32'd1);
    observe_frame(-1, -1, pad);
    wait_rise(200, n);
    check("sim_next_period", 32'(n), 32'(POLL_PERIOD - OBS_LEN));
    observe_frame(-1, -1, pad);

    // Reset during the fifth srclk low phase abandons the frame
    wait_rise(200, n);
    check("timer_period", 32'(n), 32'(POLL_PERIOD - OBS_LEN));
    repeat (LATCH_LEN + 4 * 2 * HALF + 1) tick();
    check("mid_bit4_low", 32'(srclk), 32'd0);
    reset = 1'b1;
    en    = 1'b0;
    tick();
    check("midrst_srclk",   32'(srclk),   32'd1);
    check("midrst_srlatch", 32'(srlatch), 32'd0);
    check("midrst_busy",    32'(busy),    32'd0);
    check("midrst_buttons", 32'(buttons), 32'd0);
    check("midrst_valid",   32'(valid),   32'd0);
    tick();
    reset    = 1'b0;
    exp_prev = 8'h00;
    quiet(100, "midrst_no_valid");

    // First frame after reset compares against zero
    poll_now = 1'b1;
    tick();
    poll_now = 1'b0;
    check("post_rst_rise", 32'(srlatch), 32'd1);
    observe_frame(-1, -1, pad);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
